// File: rtl/rmt_ckpt_sram_if.sv
`default_nettype none
// ============================================================================
// Module      : rmt_ckpt_sram_if
// Description : Read/write/checkpoint bundle for the rename map table.
// Revision    : 1.0 - initial release
// ============================================================================
interface rmt_ckpt_sram_if #(
    parameter int SRAM_INDEX = 5,
    parameter int SRAM_WIDTH = 7,
    parameter int NUM_RD     = 8,
    parameter int NUM_WR     = 4,
    parameter int CKPT_INDEX = 2
);
    logic [NUM_RD*SRAM_INDEX-1:0] rd_addr_i;
    logic [NUM_RD*SRAM_WIDTH-1:0] rd_data_o;
    logic [NUM_WR-1:0]            wr_en_i;
    logic [NUM_WR*SRAM_INDEX-1:0] wr_addr_i;
    logic [NUM_WR*SRAM_WIDTH-1:0] wr_data_i;
    logic                         ckpt_save_i;
    logic [CKPT_INDEX-1:0]        ckpt_id_o;
    logic                         ckpt_restore_i;
    logic [CKPT_INDEX-1:0]        ckpt_restore_id_i;
    logic                         ckpt_release_i;
    logic                         ckpt_full_o;
    logic                         ckpt_empty_o;
    logic                         ckpt_err_o;

    modport master (
        output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
        output ckpt_save_i, ckpt_restore_i, ckpt_restore_id_i, ckpt_release_i,
        input  rd_data_o, ckpt_id_o, ckpt_full_o, ckpt_empty_o, ckpt_err_o
    );

    modport slave (
        input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
        input  ckpt_save_i, ckpt_restore_i, ckpt_restore_id_i, ckpt_release_i,
        output rd_data_o, ckpt_id_o, ckpt_full_o, ckpt_empty_o, ckpt_err_o
    );
endinterface
`default_nettype wire

// File: rtl/rmt_ckpt_sram.sv
`default_nettype none
// ============================================================================
// Module      : rmt_ckpt_sram
// Description : Multi-port rename map table with a circular store of full-map
//               checkpoints (save / restore / release). Optional macro
//               RMT_BYPASS_EN forwards same-cycle write data to the reads.
// Revision    : 1.0 - initial release
// ============================================================================
module rmt_ckpt_sram #(
    parameter int SRAM_DEPTH = 32,
    parameter int SRAM_INDEX = 5,
    parameter int SRAM_WIDTH = 7,
    parameter int NUM_RD     = 8,
    parameter int NUM_WR     = 4,
    parameter int NUM_CKPT   = 4,
    parameter int CKPT_INDEX = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    rmt_ckpt_sram_if.slave bus
);
    localparam logic [CKPT_INDEX:0] c_cnt_full = (CKPT_INDEX+1)'(NUM_CKPT);
    localparam logic [CKPT_INDEX:0] c_cnt_one  = (CKPT_INDEX+1)'(1);

    logic [SRAM_WIDTH-1:0] r_map  [SRAM_DEPTH];
    logic [SRAM_WIDTH-1:0] r_slot [NUM_CKPT][SRAM_DEPTH];
    logic [CKPT_INDEX-1:0] r_head;
    logic [CKPT_INDEX-1:0] r_tail;
    logic [CKPT_INDEX:0]   r_count;
    logic                  r_err;

    logic [SRAM_WIDTH-1:0] w_nmap     [SRAM_DEPTH];
    logic [SRAM_WIDTH-1:0] w_map_next [SRAM_DEPTH];
    logic                  w_empty;
    logic                  w_rel_ok;
    logic                  w_rst_ok;
    logic                  w_sav_ok;
    logic                  w_err_set;
    logic [CKPT_INDEX-1:0] w_head_post;
    logic [CKPT_INDEX-1:0] w_rst_off;
    logic [CKPT_INDEX:0]   w_cnt_post;
    logic [CKPT_INDEX-1:0] w_tail_next;
    logic [CKPT_INDEX:0]   w_count_next;
    logic [NUM_RD*SRAM_WIDTH-1:0] w_rd_data;

    // Map with this cycle's writes applied; later ports override earlier ones.
    always_comb begin
        for (int i = 0; i < SRAM_DEPTH; i++) begin
            w_nmap[i] = r_map[i];
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wr_en_i[p]) begin
                w_nmap[bus.wr_addr_i[p*SRAM_INDEX +: SRAM_INDEX]] =
                    bus.wr_data_i[p*SRAM_WIDTH +: SRAM_WIDTH];
            end
        end
    end

    // Release is resolved first; restore legality is judged against the
    // post-release window, which also rejects restoring the slot just freed.
    always_comb begin
        w_empty     = (r_count == '0);
        w_rel_ok    = bus.ckpt_release_i && !w_empty;
        w_head_post = w_rel_ok ? r_head + CKPT_INDEX'(1) : r_head;
        w_cnt_post  = w_rel_ok ? r_count - c_cnt_one : r_count;
        w_rst_off   = bus.ckpt_restore_id_i - w_head_post;
        w_rst_ok    = bus.ckpt_restore_i && ({1'b0, w_rst_off} < w_cnt_post);
        w_sav_ok    = bus.ckpt_save_i && !bus.ckpt_restore_i && (w_cnt_post != c_cnt_full);
        w_err_set   = (bus.ckpt_release_i && w_empty) ||
                      (bus.ckpt_restore_i && !w_rst_ok) ||
                      (bus.ckpt_save_i && !bus.ckpt_restore_i && !w_sav_ok);

        w_tail_next  = r_tail;
        w_count_next = w_cnt_post;
        if (w_rst_ok) begin
            w_tail_next  = bus.ckpt_restore_id_i;
            w_count_next = {1'b0, w_rst_off};
        end else if (w_sav_ok) begin
            w_tail_next  = r_tail + CKPT_INDEX'(1);
            w_count_next = w_cnt_post + c_cnt_one;
        end
    end

    // Any restore request blocks the cycle's writes; only a legal one reloads.
    always_comb begin
        for (int i = 0; i < SRAM_DEPTH; i++) begin
            if (w_rst_ok) begin
                w_map_next[i] = r_slot[bus.ckpt_restore_id_i][i];
            end else if (bus.ckpt_restore_i) begin
                w_map_next[i] = r_map[i];
            end else begin
                w_map_next[i] = w_nmap[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SRAM_DEPTH; i++) begin
                r_map[i] <= SRAM_WIDTH'(i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            for (int i = 0; i < SRAM_DEPTH; i++) begin
                r_map[i] <= w_map_next[i];
            end
            r_head  <= w_head_post;
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
            r_err   <= r_err | w_err_set;
        end
    end

    // Snapshot storage carries no reset; slot contents are meaningless until saved.
    always_ff @(posedge clk) begin
        if (w_sav_ok) begin
            for (int i = 0; i < SRAM_DEPTH; i++) begin
                r_slot[r_tail][i] <= w_nmap[i];
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_data[k*SRAM_WIDTH +: SRAM_WIDTH] =
                r_map[bus.rd_addr_i[k*SRAM_INDEX +: SRAM_INDEX]];
`ifdef RMT_BYPASS_EN
            if (!bus.ckpt_restore_i) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (bus.wr_en_i[p] &&
                        (bus.wr_addr_i[p*SRAM_INDEX +: SRAM_INDEX] ==
                         bus.rd_addr_i[k*SRAM_INDEX +: SRAM_INDEX])) begin
                        w_rd_data[k*SRAM_WIDTH +: SRAM_WIDTH] =
                            bus.wr_data_i[p*SRAM_WIDTH +: SRAM_WIDTH];
                    end
                end
            end
`else
`endif
        end
    end

    assign bus.rd_data_o    = w_rd_data;
    assign bus.ckpt_id_o    = r_tail;
    assign bus.ckpt_full_o  = (r_count == c_cnt_full);
    assign bus.ckpt_empty_o = w_empty;
    assign bus.ckpt_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rmt_ckpt_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_rmt_ckpt_sram
// Description : Self-checking bench for rmt_ckpt_sram (table, directed, random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rmt_ckpt_sram;
    localparam int DEPTH = 32;
    localparam int IDX   = 5;
    localparam int W     = 7;
    localparam int NRD   = 8;
    localparam int NWR   = 4;
    localparam int NCK   = 4;
    localparam int CIDX  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rmt_ckpt_sram_if #(.SRAM_INDEX(IDX), .SRAM_WIDTH(W), .NUM_RD(NRD),
                       .NUM_WR(NWR), .CKPT_INDEX(CIDX)) bus ();

    rmt_ckpt_sram #(.SRAM_DEPTH(DEPTH), .SRAM_INDEX(IDX), .SRAM_WIDTH(W),
                    .NUM_RD(NRD), .NUM_WR(NWR), .NUM_CKPT(NCK),
                    .CKPT_INDEX(CIDX)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;

    // stimulus shadow
    bit s_save, s_rel, s_rst;
    int s_rid;
    bit s_we [NWR];
    int s_wa [NWR];
    int s_wd [NWR];
    int s_ra [NRD];

    // reference model: map array, snapshot array, queue of live slot ids (oldest first)
    logic [W-1:0] m_map  [DEPTH];
    logic [W-1:0] m_slot [NCK][DEPTH];
    int ids[$];
    int m_head;
    bit m_err;

    typedef struct {
        bit save, rel, rst;
        int rid;
        bit we;
        int wa, wd, ra;
        int e_rd, e_id;
        bit e_full, e_empty, e_err;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic apply();
        for (int q = 0; q < NWR; q++) begin
            bus.wr_en_i[q]              = s_we[q];
            bus.wr_addr_i[q*IDX +: IDX] = IDX'(s_wa[q]);
            bus.wr_data_i[q*W +: W]     = W'(s_wd[q]);
        end
        for (int k = 0; k < NRD; k++) bus.rd_addr_i[k*IDX +: IDX] = IDX'(s_ra[k]);
        bus.ckpt_save_i       = s_save;
        bus.ckpt_release_i    = s_rel;
        bus.ckpt_restore_i    = s_rst;
        bus.ckpt_restore_id_i = CIDX'(s_rid);
    endtask

    task automatic idle();
        s_save = 0; s_rel = 0; s_rst = 0; s_rid = 0;
        for (int q = 0; q < NWR; q++) begin s_we[q] = 0; s_wa[q] = 0; s_wd[q] = 0; end
        apply();
    endtask

    task automatic set_ra(input int a);
        for (int k = 0; k < NRD; k++) s_ra[k] = a;
        apply();
    endtask

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) m_map[a] = W'(a);
        ids.delete();
        m_head = 0;
        m_err  = 0;
    endtask

    function automatic int exp_read(input int a);
        int v;
        v = int'(m_map[a]);
`ifdef RMT_BYPASS_EN
        if (!s_rst)
            for (int q = 0; q < NWR; q++)
                if (s_we[q] && s_wa[q] == a) v = s_wd[q];
`endif
        return v;
    endfunction

    task automatic model_step();
        logic [W-1:0] nm [DEPTH];
        int  p;
        int  t;
        bit  found;
        if (s_rel) begin
            if (ids.size() == 0) m_err = 1;
            else begin void'(ids.pop_front()); m_head = (m_head + 1) % NCK; end
        end
        if (s_rst) begin
            found = 0; p = 0;
            for (int i = 0; i < ids.size(); i++)
                if (!found && ids[i] == s_rid) begin found = 1; p = i; end
            if (found) begin
                for (int a = 0; a < DEPTH; a++) m_map[a] = m_slot[s_rid][a];
                while (ids.size() > p) void'(ids.pop_back());
            end else m_err = 1;
        end else begin
            for (int a = 0; a < DEPTH; a++) nm[a] = m_map[a];
            for (int q = 0; q < NWR; q++) if (s_we[q]) nm[s_wa[q]] = W'(s_wd[q]);
            if (s_save) begin
                if (ids.size() == NCK) m_err = 1;
                else begin
                    t = (m_head + ids.size()) % NCK;
                    for (int a = 0; a < DEPTH; a++) m_slot[t][a] = nm[a];
                    ids.push_back(t);
                end
            end
            for (int a = 0; a < DEPTH; a++) m_map[a] = nm[a];
        end
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < NRD; k++)
            chk({tag, "_rd"}, int'(bus.rd_data_o[k*W +: W]), exp_read(s_ra[k]));
        chk({tag, "_id"},    int'(bus.ckpt_id_o),    (m_head + ids.size()) % NCK);
        chk({tag, "_full"},  int'(bus.ckpt_full_o),  int'(ids.size() == NCK));
        chk({tag, "_empty"}, int'(bus.ckpt_empty_o), int'(ids.size() == 0));
        chk({tag, "_err"},   int'(bus.ckpt_err_o),   int'(m_err));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    function automatic vec_t mk(input bit sv, input bit rl, input bit rs, input int rid,
                                input bit we, input int wa, input int wd, input int ra,
                                input int erd, input int eid, input bit ef,
                                input bit ee, input bit eerr);
        vec_t v;
        v.save = sv; v.rel = rl; v.rst = rs; v.rid = rid;
        v.we = we; v.wa = wa; v.wd = wd; v.ra = ra;
        v.e_rd = erd; v.e_id = eid; v.e_full = ef; v.e_empty = ee; v.e_err = eerr;
        return v;
    endfunction

    initial begin
        reset = 1'b0;
        for (int k = 0; k < NRD; k++) s_ra[k] = 0;
        idle();

        // sequence of checkpoint operations, outputs checked after each edge
        tbl.push_back(mk(1,0,0,0, 1,5,70, 5, 70,1,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,5,90, 5, 90,1,0,0,0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,  5, 70,0,0,1,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,  5, 70,1,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,  5, 70,2,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,  5, 70,3,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,  5, 70,0,1,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,  5, 70,0,1,0,1));
        tbl.push_back(mk(1,1,0,0, 1,5,11, 5, 11,1,1,0,1));
        tbl.push_back(mk(0,0,1,3, 0,0,0,  5, 70,3,0,0,1));
        tbl.push_back(mk(0,1,1,1, 0,0,0,  5, 70,3,0,0,1));
        tbl.push_back(mk(0,1,0,0, 0,0,0,  5, 70,3,0,1,1));
        tbl.push_back(mk(0,1,0,0, 0,0,0,  5, 70,3,0,1,1));

        // reset state: every address through every port
        do_reset();
        for (int a = 0; a < DEPTH; a++) begin
            for (int k = 0; k < NRD; k++) s_ra[k] = (a + k) % DEPTH;
            apply();
            #1;
            for (int k = 0; k < NRD; k++)
                chk("reset_rd", int'(bus.rd_data_o[k*W +: W]), (a + k) % DEPTH);
        end
        chk("reset_empty", int'(bus.ckpt_empty_o), 1);
        chk("reset_full",  int'(bus.ckpt_full_o),  0);
        chk("reset_id",    int'(bus.ckpt_id_o),    0);
        chk("reset_err",   int'(bus.ckpt_err_o),   0);

        // write conflict on one address
        @(negedge clk);
        idle();
        s_we[0] = 1; s_wa[0] = 3; s_wd[0] = 40;
        s_we[3] = 1; s_wa[3] = 3; s_wd[3] = 55;
        set_ra(3);
        #1;
`ifdef RMT_BYPASS_EN
        chk("conflict_same_cycle", int'(bus.rd_data_o[0 +: W]), 55);
`else
        chk("conflict_same_cycle", int'(bus.rd_data_o[0 +: W]), 3);
`endif
        @(posedge clk); #1; idle(); #1;
        chk("conflict_next", int'(bus.rd_data_o[0 +: W]), 55);

        // table
        do_reset();
        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            idle();
            s_save = tbl[r].save; s_rel = tbl[r].rel; s_rst = tbl[r].rst; s_rid = tbl[r].rid;
            s_we[0] = tbl[r].we; s_wa[0] = tbl[r].wa; s_wd[0] = tbl[r].wd;
            set_ra(tbl[r].ra);
            @(posedge clk); #1; idle(); #1;
            chk("tbl_rd0",   int'(bus.rd_data_o[0 +: W]),         tbl[r].e_rd);
            chk("tbl_rdN",   int'(bus.rd_data_o[(NRD-1)*W +: W]), tbl[r].e_rd);
            chk("tbl_id",    int'(bus.ckpt_id_o),    tbl[r].e_id);
            chk("tbl_full",  int'(bus.ckpt_full_o),  int'(tbl[r].e_full));
            chk("tbl_empty", int'(bus.ckpt_empty_o), int'(tbl[r].e_empty));
            chk("tbl_err",   int'(bus.ckpt_err_o),   int'(tbl[r].e_err));
        end

        // release together with restore of the old head
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            s_save = 1; s_we[1] = 1; s_wa[1] = 7; s_wd[1] = 100 + i;
            apply();
        end
        @(negedge clk); idle();
        s_rel = 1; s_rst = 1; s_rid = 0; set_ra(7);
        @(posedge clk); #1; idle(); #1;
        chk("relrst_err", int'(bus.ckpt_err_o), 1);
        chk("relrst_id",  int'(bus.ckpt_id_o),  3);
        chk("relrst_map", int'(bus.rd_data_o[0 +: W]), 102);
        @(negedge clk); s_rel = 1; apply();
        @(posedge clk); #1; idle(); #1;
        chk("relrst_cnt1", int'(bus.ckpt_empty_o), 0);
        @(negedge clk); s_rel = 1; apply();
        @(posedge clk); #1; idle(); #1;
        chk("relrst_cnt0", int'(bus.ckpt_empty_o), 1);

        // restore of a middle slot with a same-cycle write
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            s_save = 1; s_we[1] = 1; s_wa[1] = 7; s_wd[1] = 100 + i;
            apply();
        end
        @(negedge clk); idle();
        s_rst = 1; s_rid = 1; s_we[2] = 1; s_wa[2] = 7; s_wd[2] = 50; set_ra(7);
        #1;
        chk("restore_nobypass", int'(bus.rd_data_o[0 +: W]), 102);
        @(posedge clk); #1; idle(); #1;
        chk("restore_map",   int'(bus.rd_data_o[0 +: W]), 101);
        chk("restore_id",    int'(bus.ckpt_id_o),  1);
        chk("restore_err",   int'(bus.ckpt_err_o), 0);
        chk("restore_nempt", int'(bus.ckpt_empty_o), 0);
        @(negedge clk); s_rel = 1; apply();
        @(posedge clk); #1; idle(); #1;
        chk("restore_cnt1", int'(bus.ckpt_empty_o), 1);

        // asynchronous reset in the middle of a save cycle
        @(negedge clk); idle();
        s_rel = 1; s_we[0] = 1; s_wa[0] = 5; s_wd[0] = 9; set_ra(5);
        @(posedge clk); #1;
        chk("pre_async_err", int'(bus.ckpt_err_o), 1);
        @(negedge clk); idle();
        s_save = 1; s_we[0] = 1; s_wa[0] = 5; s_wd[0] = 33; set_ra(5);
        #2;
        reset = 1'b0;
        #1;
        idle();
        set_ra(5);
        #0;
        chk("async_map",   int'(bus.rd_data_o[0 +: W]), 5);
        chk("async_err",   int'(bus.ckpt_err_o),   0);
        chk("async_empty", int'(bus.ckpt_empty_o), 1);
        chk("async_id",    int'(bus.ckpt_id_o),    0);
        #1;
        reset = 1'b1;
        model_reset();

        // randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            s_save = ($urandom_range(0, 99) < 40);
            s_rel  = ($urandom_range(0, 99) < 30);
            s_rst  = ($urandom_range(0, 99) < 15);
            s_rid  = $urandom_range(0, NCK-1);
            for (int q = 0; q < NWR; q++) begin
                s_we[q] = s_rst ? 1'b0 : 1'($urandom_range(0, 1));
                s_wa[q] = $urandom_range(0, 7);
                s_wd[q] = $urandom_range(0, 127);
            end
            for (int k = 0; k < NRD; k++) s_ra[k] = $urandom_range(0, DEPTH-1);
            apply();
            #1;
            check_model("rand");
            @(posedge clk);
            model_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
